loop_buffer_blk_ring: RTL

Block-granular ring buffer for the CPRI packing path. The writer fills one fixed-size block at a time by word address and commits it with a last-beat marker plus a per-block info word. The reader addresses words inside the oldest committed block and releases it with a one-cycle pulse. Block count, data width, read latency and full-buffer drop handling are parametrised. Block accounting is exact under simultaneous commit and release.

---
 rtl/loop_buf_pkg.sv | 33 +++
 rtl/loop_buf_sdp_ram.sv | 63 ++++++
 rtl/loop_buffer_blk_ring.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/loop_buf_pkg.sv
// loop_buf_pkg
// Shared constants for the block-granular loop buffer:
//   - RD_LAT legal range and a check function
//   - err_sticky bit indices
//   - block counter width derived from BLK_W
//   - write-side FSM state encoding
package loop_buf_pkg;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 3;

   // err_sticky bit positions
   localparam int ERR_REL_EMPTY = 0;
   localparam int ERR_DROP      = 1;

   // Write-side block state: no block open, filling a kept block,
   // or swallowing a block that found the ring full when it opened.
   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_FILL = 2'd1,
      WR_DROP = 2'd2
   } wr_state_t;

   function automatic bit rd_lat_ok(input int lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

   // free/used counters must represent 0..NUM_BLK inclusive
   function automatic int cnt_width(input int blk_w);
      return blk_w + 1;
   endfunction

endpackage

// File: rtl/loop_buf_sdp_ram.sv
// loop_buf_sdp_ram
// Simple dual-port RAM: one write port, one read port, registered read
// followed by RD_LAT-1 extra pipeline stages. The data path has no reset;
// only the read-valid pipe is reset so rd_vld is clean after rst.
// A read of an address written in the same cycle returns the old word.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (valid pipe only)
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr           read request
//   rd_data/rd_vld          read result, RD_LAT cycles after rd_en
module loop_buf_sdp_ram #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_vld
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_reg [DEPTH];
   logic [DATA_W-1:0] q_reg   [RD_LAT];
   logic [RD_LAT-1:0] vld_reg;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_reg[wr_addr] <= wr_data;
      end
   end

   // First stage is the RAM output register; later stages just delay it.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         q_reg[0] <= mem_reg[rd_addr];
      end
      for (int i = 1; i < RD_LAT; i++) begin
         q_reg[i] <= q_reg[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_reg <= '0;
      end else begin
         vld_reg[0] <= rd_en;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_reg[i] <= vld_reg[i-1];
         end
      end
   end

   assign rd_data = q_reg[RD_LAT-1];
   assign rd_vld  = vld_reg[RD_LAT-1];

endmodule

// File: rtl/loop_buffer_blk_ring.sv
// loop_buffer_blk_ring
// Block-granular ring buffer. The writer fills one 2**ADDR_W-word block at
// a time and commits it with wr_last (plus an info word); the reader reads
// words of the oldest committed block and releases it with rd_rdy.
// A block that opens while the ring is full is swallowed whole and reported
// with wr_drop when it closes.
// Optional feature macro: LOOP_BUF_INFO_EN (per-block info storage; when
// undefined, wr_info is ignored and rd_info is 0).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data         write beat into the open block
//   wr_last/wr_info               close block, info word sampled at close
//   wr_drop                       pulse: block just closed was discarded
//   free_blk/used_blk             block accounting (registered)
//   rd_vld/rd_info                head block present / its info word
//   rd_en/rd_addr                 read a word of the head block
//   rd_data/rd_data_vld           read result, RD_LAT cycles later
//   rd_rdy                        release head block
//   err_sticky                    bit0 release while empty, bit1 drop
import loop_buf_pkg::*;

module loop_buffer_blk_ring #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 8,
   parameter int BLK_W  = 2,
   parameter int INFO_W = 32,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_last,
   input  logic [INFO_W-1:0] wr_info,
   output logic              wr_drop,
   output logic [BLK_W:0]    free_blk,
   output logic [BLK_W:0]    used_blk,
   output logic              rd_vld,
   output logic [INFO_W-1:0] rd_info,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_data_vld,
   input  logic              rd_rdy,
   output logic [1:0]        err_sticky
);

   localparam int NUM_BLK = 1 << BLK_W;
   localparam int CNT_W   = cnt_width(BLK_W);
   localparam logic [CNT_W-1:0] NUM_BLK_CNT = CNT_W'(NUM_BLK);

   generate
      if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
         $error("loop_buffer_blk_ring: RD_LAT must be 1..3");
      end
   endgenerate

   wr_state_t         state_reg, state_next;
   logic [BLK_W-1:0]  wptr_reg, rptr_reg;
   logic [CNT_W-1:0]  used_reg, used_next, free_reg;
   logic              wr_drop_reg;
   logic [1:0]        err_reg;

   logic              drop_now;
   logic              ram_we;
   logic              commit;
   logic              drop_close;
   logic              release_ok;
   logic              release_bad;

   logic [DATA_W-1:0] ram_q;
   logic              ram_vld;

   // ---------------- write-side FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= WR_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // A single-beat block (wr_en & wr_last on the opening beat) stays in IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         WR_IDLE: begin
            if (wr_en && !wr_last) begin
               state_next = (free_reg == '0) ? WR_DROP : WR_FILL;
            end
         end
         WR_FILL, WR_DROP: begin
            if (wr_en && wr_last) begin
               state_next = WR_IDLE;
            end
         end
         default: state_next = WR_IDLE;
      endcase
   end

   // The drop decision is taken on the opening beat from the registered
   // free count; afterwards the state carries it to the block's end.
   always_comb begin
      drop_now   = 1'b0;
      ram_we     = 1'b0;
      commit     = 1'b0;
      drop_close = 1'b0;
      case (state_reg)
         WR_IDLE: drop_now = (free_reg == '0);
         WR_DROP: drop_now = 1'b1;
         default: drop_now = 1'b0;
      endcase
      ram_we     = wr_en && !drop_now;
      commit     = wr_en && wr_last && !drop_now;
      drop_close = wr_en && wr_last && drop_now;
   end

   // ---------------- block accounting ----------------
   assign release_ok  = rd_rdy && (used_reg != '0);
   assign release_bad = rd_rdy && (used_reg == '0);

   always_comb begin
      used_next = used_reg;
      if (commit && !release_ok) begin
         used_next = used_reg + CNT_W'(1);
      end else if (!commit && release_ok) begin
         used_next = used_reg - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_reg    <= '0;
         rptr_reg    <= '0;
         used_reg    <= '0;
         free_reg    <= NUM_BLK_CNT;
         wr_drop_reg <= 1'b0;
         err_reg     <= '0;
      end else begin
         if (commit) begin
            wptr_reg <= wptr_reg + BLK_W'(1);
         end
         if (release_ok) begin
            rptr_reg <= rptr_reg + BLK_W'(1);
         end
         used_reg    <= used_next;
         free_reg    <= NUM_BLK_CNT - used_next;
         wr_drop_reg <= drop_close;
         if (release_bad) begin
            err_reg[ERR_REL_EMPTY] <= 1'b1;
         end
         if (drop_close) begin
            err_reg[ERR_DROP] <= 1'b1;
         end
      end
   end

   // ---------------- per-block info ----------------
`ifdef LOOP_BUF_INFO_EN
   logic [INFO_W-1:0] info_reg [NUM_BLK];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_BLK; i++) begin
            info_reg[i] <= '0;
         end
      end else if (commit) begin
         info_reg[wptr_reg] <= wr_info;
      end
   end

   assign rd_info = info_reg[rptr_reg];
`else
   logic unused_info;
   assign unused_info = ^wr_info;
   assign rd_info     = '0;
`endif

   // ---------------- data storage ----------------
   loop_buf_sdp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (BLK_W + ADDR_W),
      .RD_LAT (RD_LAT)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (ram_we),
      .wr_addr ({wptr_reg, wr_addr}),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr ({rptr_reg, rd_addr}),
      .rd_data (ram_q),
      .rd_vld  (ram_vld)
   );

   // RAM output is unreset; hold rd_data at 0 outside valid beats.
   assign rd_data     = ram_vld ? ram_q : '0;
   assign rd_data_vld = ram_vld;

   assign wr_drop    = wr_drop_reg;
   assign free_blk   = free_reg;
   assign used_blk   = used_reg;
   assign rd_vld     = (used_reg != '0);
   assign err_sticky = err_reg;

endmodule
